// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard/stall controller: load-use bubbles, branch
//                flushes, cache-miss freeze with watchdog, stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     ID_Instr,
    input  logic            ID_useRs,
    input  logic            ID_useRt,
    input  logic            IE_memRead,
    input  logic            IE_regWrite,
    input  logic [2:0]      IE_writereg,
    input  logic            IE_branchTaken,
    input  logic            M_memBusy,
    input  logic            M_memDone,
    output logic            PC_write,
    output logic            IFID_write,
    output logic            IDEX_bubble,
    output logic            IFID_flush,
    output logic            pipe_hold,
    output logic            mem_timeout,
    output logic [CNTW-1:0] stall_cycles
);

    localparam int                c_WAITW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAITW-1:0] c_WAIT_MAX = c_WAITW'(TIMEOUT);
    localparam logic [0:0]        c_RUN      = 1'b0;
    localparam logic [0:0]        c_MEM_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_WAITW-1:0] r_wait_cnt;
    logic [c_WAITW-1:0] w_wait_nxt;
    logic               r_mem_timeout;
    logic [CNTW-1:0]    r_stall_cycles;
    logic               w_lu_hazard;
    logic               w_unused_instr;

    // Only the register-specifier fields of the instruction matter here.
    assign w_unused_instr = ^{ID_Instr[15:11], ID_Instr[4:0]};

    assign w_lu_hazard = IE_memRead & IE_regWrite &
                         ((ID_useRs & (IE_writereg == ID_Instr[10:8])) |
                          (ID_useRt & (IE_writereg == ID_Instr[7:5])));

    always_comb begin
        w_state_nxt = r_state;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        pipe_hold   = 1'b0;
        if (rst) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
            IFID_flush  = 1'b1;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (M_memBusy) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        pipe_hold   = 1'b1;
                        w_state_nxt = c_MEM_WAIT;
                    end else if (IE_branchTaken) begin
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                    end else if (w_lu_hazard) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                    end
                end
                default: begin
                    // Frozen until the cache reports completion; done wins over busy.
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    pipe_hold  = 1'b1;
                    if (M_memDone) begin
                        w_state_nxt = c_RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (r_state == c_RUN) begin
            if (w_state_nxt == c_MEM_WAIT) begin
                w_wait_nxt = '0;
            end
        end else if (r_wait_cnt != c_WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if ((r_state == c_MEM_WAIT) && (w_wait_nxt == c_WAIT_MAX)) begin
                r_mem_timeout <= 1'b1;
            end
            if (!PC_write && (r_stall_cycles != {CNTW{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl (vector table plus
//                directed multi-cycle sequences, queue-based scoreboard).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;
    localparam logic [15:0] c_INSTR = 16'h03A0;  // Rs=3, Rt=5

    logic            clk;
    logic            rst;
    logic [15:0]     ID_Instr;
    logic            ID_useRs;
    logic            ID_useRt;
    logic            IE_memRead;
    logic            IE_regWrite;
    logic [2:0]      IE_writereg;
    logic            IE_branchTaken;
    logic            M_memBusy;
    logic            M_memDone;
    logic            PC_write;
    logic            IFID_write;
    logic            IDEX_bubble;
    logic            IFID_flush;
    logic            pipe_hold;
    logic            mem_timeout;
    logic [CNTW-1:0] stall_cycles;

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ID_Instr       (ID_Instr),
        .ID_useRs       (ID_useRs),
        .ID_useRt       (ID_useRt),
        .IE_memRead     (IE_memRead),
        .IE_regWrite    (IE_regWrite),
        .IE_writereg    (IE_writereg),
        .IE_branchTaken (IE_branchTaken),
        .M_memBusy      (M_memBusy),
        .M_memDone      (M_memDone),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .IDEX_bubble    (IDEX_bubble),
        .IFID_flush     (IFID_flush),
        .pipe_hold      (pipe_hold),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected controls packed as {PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_hold}
    typedef struct {
        logic [15:0] instr;
        logic        use_rs;
        logic        use_rt;
        logic        mem_read;
        logic        reg_write;
        logic [2:0]  wreg;
        logic        branch;
        logic        busy;
        logic        done;
        logic [4:0]  exp;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] sb_q[$];
    vec_t       tbl[14];

    function automatic vec_t mk(input logic [15:0] instr, input logic urs, input logic urt,
                                input logic mr, input logic rw, input logic [2:0] wr,
                                input logic br, input logic busy, input logic done,
                                input logic [4:0] exp);
        vec_t v;
        v.instr = instr; v.use_rs = urs; v.use_rt = urt; v.mem_read = mr;
        v.reg_write = rw; v.wreg = wr; v.branch = br; v.busy = busy;
        v.done = done; v.exp = exp;
        return v;
    endfunction

    function automatic logic [4:0] ctl();
        return {PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_hold};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_Instr       = v.instr;
        ID_useRs       = v.use_rs;
        ID_useRt       = v.use_rt;
        IE_memRead     = v.mem_read;
        IE_regWrite    = v.reg_write;
        IE_writereg    = v.wreg;
        IE_branchTaken = v.branch;
        M_memBusy      = v.busy;
        M_memDone      = v.done;
    endtask

    // One cycle: drive at the falling edge, score the combinational controls 1ns later.
    task automatic apply(input string name, input vec_t v);
        logic [4:0] e;
        @(negedge clk);
        drive(v);
        sb_q.push_back(v.exp);
        #1;
        e = sb_q.pop_front();
        check(name, {27'd0, ctl()}, {27'd0, e});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({name, "_stall"}, {28'd0, stall_cycles}, 32'd0);
        check({name, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
        check({name, "_ctl"}, {27'd0, ctl()}, {27'd0, 5'b00110});
        @(negedge clk);
        drive(mk(16'h0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 5'b11000));
        rst = 1'b0;
    endtask

    initial begin
        vec_t idle;
        vec_t hold;
        idle = mk(16'h0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 5'b11000);
        hold = mk(c_INSTR, 0, 0, 0, 0, 3'd0, 0, 0, 0, 5'b00001);

        tbl[0]  = idle;
        tbl[1]  = mk(c_INSTR, 1, 0, 1, 1, 3'd3, 0, 0, 0, 5'b00100);  // load-use on Rs
        tbl[2]  = mk(c_INSTR, 1, 0, 0, 1, 3'd3, 0, 0, 0, 5'b11000);  // load gone
        tbl[3]  = mk(c_INSTR, 0, 0, 1, 1, 3'd3, 0, 0, 0, 5'b11000);  // false hazard
        tbl[4]  = mk(c_INSTR, 0, 1, 1, 1, 3'd5, 0, 0, 0, 5'b00100);  // load-use on Rt
        tbl[5]  = mk(c_INSTR, 0, 1, 1, 1, 3'd3, 0, 0, 0, 5'b11000);  // Rt not matching
        tbl[6]  = mk(c_INSTR, 1, 0, 1, 0, 3'd3, 0, 0, 0, 5'b11000);  // no regWrite
        tbl[7]  = mk(c_INSTR, 1, 0, 1, 1, 3'd3, 1, 0, 0, 5'b11110);  // branch beats hazard
        tbl[8]  = mk(16'h0,   0, 0, 0, 0, 3'd0, 1, 0, 0, 5'b11110);  // branch alone
        tbl[9]  = mk(c_INSTR, 1, 0, 1, 1, 3'd3, 1, 1, 0, 5'b00001);  // busy beats all
        tbl[10] = mk(c_INSTR, 1, 0, 1, 1, 3'd3, 1, 1, 0, 5'b00001);  // MEM_WAIT ignores inputs
        tbl[11] = mk(16'h0,   0, 0, 0, 0, 3'd0, 0, 1, 1, 5'b00001);  // busy+done = done
        tbl[12] = mk(c_INSTR, 1, 0, 1, 1, 3'd3, 0, 0, 0, 5'b00100);  // first RUN cycle normal
        tbl[13] = idle;

        rst = 1'b1;
        drive(idle);
        #2;
        check("rst_ctl", {27'd0, ctl()}, {27'd0, 5'b00110});
        check("rst_stall", {28'd0, stall_cycles}, 32'd0);
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_stall", {28'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("tbl[%0d]", i), tbl[i]);
        end
        check("tbl_stall", {28'd0, stall_cycles}, 32'd6);
        check("tbl_timeout", {31'd0, mem_timeout}, 32'd0);

        // Single load-use pair yields exactly one bubble.
        do_reset("async1");
        apply("lu_stall", tbl[1]);
        apply("lu_resume", mk(c_INSTR, 1, 0, 0, 1, 3'd3, 0, 0, 0, 5'b11000));
        check("lu_count", {28'd0, stall_cycles}, 32'd1);

        // Cache miss: busy one cycle, done on the fifth hold cycle.
        do_reset("async2");
        apply("miss_busy", mk(16'h0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 5'b00001));
        for (int k = 0; k < 3; k++) apply($sformatf("miss_wait%0d", k), hold);
        apply("miss_done", mk(16'h0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 5'b00001));
        apply("miss_run", idle);
        check("miss_count", {28'd0, stall_cycles}, 32'd5);

        // Watchdog, stall-counter saturation, then reset in the middle of the wait.
        do_reset("async3");
        apply("wd_busy", mk(16'h0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 5'b00001));
        for (int k = 1; k <= 20; k++) begin
            apply($sformatf("wd_hold%0d", k), hold);
            check($sformatf("wd_timeout%0d", k), {31'd0, mem_timeout},
                  {31'd0, ((k - 1) >= TIMEOUT)});
            check($sformatf("wd_stall%0d", k), {28'd0, stall_cycles},
                  (k > 15) ? 32'd15 : k);
        end
        do_reset("async_midwait");
        apply("post_rst_run", tbl[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the MEM_WAIT cycle count at which mem_timeout sets.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of stall_cycles.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port ID_Instr, input, 16, the decode-stage instruction; Rs = [10:8], Rt = [7:5].
REQ-006 The block SHALL have ports ID_useRs and ID_useRt, input, 1 each, set when the decode instruction reads Rs or Rt.
REQ-007 The block SHALL have ports IE_memRead and IE_regWrite, input, 1 each, the execute-stage load and register-write flags.
REQ-008 The block SHALL have port IE_writereg, input, 3, the execute-stage destination register.
REQ-009 The block SHALL have port IE_branchTaken, input, 1, set when a branch or jump resolves taken in execute.
REQ-010 The block SHALL have ports M_memBusy and M_memDone, input, 1 each, the memory-stage cache busy and completion flags.
REQ-011 The block SHALL have ports PC_write, IFID_write, IDEX_bubble, IFID_flush and pipe_hold, output, 1 each, the pipeline controls.
REQ-012 The block SHALL have port mem_timeout, output, 1, a sticky watchdog flag.
REQ-013 The block SHALL have port stall_cycles, output, CNTW, a saturating stall counter.

Function
REQ-014 The block SHALL define lu_hazard = IE_memRead & IE_regWrite & ((ID_useRs & IE_writereg==ID_Instr[10:8]) | (ID_useRt & IE_writereg==ID_Instr[7:5])).
REQ-015 The FSM SHALL have exactly two states, RUN and MEM_WAIT; all outputs SHALL be combinational from state and current inputs, with no added latency.
REQ-016 In RUN with M_memBusy=1, the block SHALL drive PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0 and pipe_hold=1, with next state MEM_WAIT.
REQ-017 In RUN with M_memBusy=0 and IE_branchTaken=1, the block SHALL drive PC_write=1, IFID_write=1, IFID_flush=1, IDEX_bubble=1 and pipe_hold=0; branch SHALL override lu_hazard.
REQ-018 In RUN with no busy, no branch and lu_hazard=1, the block SHALL drive PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0 and pipe_hold=0, giving exactly one bubble per load-use pair.
REQ-019 In RUN with no condition active, the block SHALL drive PC_write=1, IFID_write=1 and all other controls 0.
REQ-020 Priority SHALL be M_memBusy > IE_branchTaken > lu_hazard.
REQ-021 In MEM_WAIT, the block SHALL drive PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0 and pipe_hold=1 regardless of other inputs, including M_memDone.
REQ-022 In MEM_WAIT with M_memDone=1, next state SHALL be RUN; the first RUN cycle SHALL evaluate REQ-016..019 normally.
REQ-023 M_memBusy and M_memDone both high in MEM_WAIT SHALL be treated as done.
REQ-024 A wait counter SHALL clear on RUN->MEM_WAIT and increment each MEM_WAIT cycle, saturating at TIMEOUT.
REQ-025 mem_timeout SHALL set on the edge where the wait counter reaches TIMEOUT and SHALL hold until rst.
REQ-026 stall_cycles SHALL increment on each clock edge where PC_write was 0 outside reset, saturating at all-ones with no wrap.

Reset
REQ-027 While rst=1, the block SHALL force state=RUN, wait counter=0, mem_timeout=0 and stall_cycles=0 immediately, without waiting for clk.
REQ-028 While rst=1, outputs SHALL be PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=1 and pipe_hold=0.
REQ-029 rst asserted in MEM_WAIT SHALL abandon the wait; after release, the first cycle SHALL be RUN.

Verification
REQ-030 Load-use: IE_memRead=1, IE_regWrite=1, IE_writereg=3, ID_Instr[10:8]=3, ID_useRs=1 -> one cycle PC_write=0, IDEX_bubble=1; next cycle with IE_memRead=0 -> PC_write=1; stall_cycles=1.
REQ-031 False hazard: same as REQ-030 but ID_useRs=0 and ID_useRt=0 -> PC_write=1, IDEX_bubble=0.
REQ-032 Branch vs hazard: IE_branchTaken=1 with lu_hazard=1 -> IFID_flush=1, IDEX_bubble=1, PC_write=1.
REQ-033 Cache miss: M_memBusy=1 for 1 cycle, M_memDone=1 on the 5th cycle -> pipe_hold=1 for 5 cycles, then RUN; stall_cycles=5.
REQ-034 Watchdog and reset: TIMEOUT=4, hold MEM_WAIT 6 cycles -> mem_timeout=1 after the 4th MEM_WAIT edge; assert rst mid-wait -> state RUN, mem_timeout=0 and stall_cycles=0 asynchronously.
